// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: default sizing shared by the store buffer and its forwarding matcher.
package store_buffer_pkg;
  localparam int SQ_SIZE    = 8;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ROB_SEL    = 5;
endpackage

// File: rtl/store_buffer_sq_fwd_match.sv
// sq_fwd_match: picks the youngest older store overlapping a load; stalls on partial cover or unexecuted older stores.
module sq_fwd_match #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / 8
) (
  input  logic [IDX_W:0]       i_head,
  input  logic [IDX_W:0]       i_ld_idx,
  input  logic [ADDR_W-1:0]    i_ld_addr,
  input  logic [BE_W-1:0]      i_ld_be,
  input  logic [DEPTH-1:0]     i_valid,
  input  logic [DEPTH-1:0]     i_exec,
  input  logic [ADDR_W-1:0]    i_addr [DEPTH],
  input  logic [DATA_W-1:0]    i_data [DEPTH],
  input  logic [BE_W-1:0]      i_be   [DEPTH],
  output logic                 o_hit,
  output logic                 o_stall,
  output logic [DATA_W-1:0]    o_data
);
  localparam int OFF = $clog2(BE_W);
  logic [IDX_W:0]   w_span;
  logic [IDX_W-1:0] w_e;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_unexec;
  logic             w_cover;
  logic             w_unused;
  assign w_unused = ^i_ld_addr;
  always_comb begin
    w_span   = i_ld_idx - i_head;
    w_e      = '0;
    w_idx    = '0;
    w_found  = 1'b0;
    w_unexec = 1'b0;
    // Walking oldest to youngest lets the last match win.
    for (int d = 0; d < DEPTH; d++) begin
      w_e = i_head[IDX_W-1:0] + IDX_W'(d);
      if ((IDX_W+1)'(d) < w_span && i_valid[w_e]) begin
        if (!i_exec[w_e]) w_unexec = 1'b1;
        else if (i_addr[w_e][ADDR_W-1:OFF] == i_ld_addr[ADDR_W-1:OFF] && |(i_be[w_e] & i_ld_be)) begin
          w_found = 1'b1;
          w_idx   = w_e;
        end
      end
    end
    w_cover = (i_be[w_idx] & i_ld_be) == i_ld_be;
    o_hit   = w_found && w_cover && !w_unexec;
    o_stall = w_unexec || (w_found && !w_cover);
    o_data  = o_hit ? i_data[w_idx] : '0;
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: in-order LSU store queue with speculative/committed split, memory drain and load probe.
// Store-to-load forwarding is built only when SQ_FORWARD_EN is defined; otherwise matching loads stall.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SQ_SIZE,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int ROB_W  = ROB_SEL,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [ROB_W-1:0]      alloc_rob_idx,
  output logic [IDX_W:0]        alloc_sq_idx,
  input  logic                  exec_valid,
  input  logic [IDX_W-1:0]      exec_sq_idx,
  input  logic [ADDR_W-1:0]     exec_addr,
  input  logic [DATA_W-1:0]     exec_data,
  input  logic [DATA_W/8-1:0]   exec_be,
  input  logic                  commit_valid,
  input  logic                  flush,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic [DATA_W-1:0]     mem_req_data,
  output logic [DATA_W/8-1:0]   mem_req_be,
  input  logic                  ld_valid,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [DATA_W/8-1:0]   ld_be,
  input  logic [IDX_W:0]        ld_sq_idx,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_data,
  output logic                  fwd_stall,
  output logic                  sq_full,
  output logic                  sq_empty,
  output logic [IDX_W:0]        sq_count
);
  localparam int BE_W = DATA_W / 8;
  logic [IDX_W:0]     r_head, r_cmt, r_tail;
  logic [DEPTH-1:0]   r_valid, r_exec;
  logic [ROB_W-1:0]   r_rob  [DEPTH];
  logic [ADDR_W-1:0]  r_addr [DEPTH];
  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [BE_W-1:0]    r_be   [DEPTH];
  logic [IDX_W-1:0]   w_head_i, w_cmt_i, w_tail_i, w_off;
  logic [IDX_W:0]     w_spec;
  logic [DEPTH-1:0]   w_kill;
  logic               w_alloc, w_exec, w_commit_ok, w_commit, w_drain;
  logic               w_hit, w_stall;
  logic [DATA_W-1:0]  w_fwd;
  assign w_head_i      = r_head[IDX_W-1:0];
  assign w_cmt_i       = r_cmt[IDX_W-1:0];
  assign w_tail_i      = r_tail[IDX_W-1:0];
  assign sq_count      = r_tail - r_head;
  assign sq_full       = sq_count == (IDX_W+1)'(DEPTH);
  assign sq_empty      = sq_count == '0;
  assign alloc_ready   = !sq_full;
  assign alloc_sq_idx  = r_tail;
  assign mem_req_valid = r_head != r_cmt;
  assign mem_req_addr  = r_addr[w_head_i];
  assign mem_req_data  = r_data[w_head_i];
  assign mem_req_be    = r_be[w_head_i];
  assign w_alloc       = alloc_valid && alloc_ready && !flush;
  assign w_exec        = exec_valid && r_valid[exec_sq_idx] && !flush;
  assign w_commit_ok   = r_cmt != r_tail && r_exec[w_cmt_i];
  assign w_commit      = commit_valid && w_commit_ok && !flush;
  assign w_drain       = mem_req_valid && mem_req_ready;
  assign w_spec        = r_tail - r_cmt;
  // Entries in [cmt,tail) are the speculative ones a flush throws away.
  always_comb begin
    w_off  = '0;
    w_kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off     = IDX_W'(i) - w_cmt_i;
      w_kill[i] = {1'b0, w_off} < w_spec;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_cmt   <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_exec  <= '0;
    end else begin
      if (commit_valid && !flush)
        assert (w_commit_ok) else $warning("store_buffer: commit ignored, entry for rob %0d not executable", r_rob[w_cmt_i]);
      if (w_drain) begin
        r_valid[w_head_i] <= 1'b0;
        r_exec[w_head_i]  <= 1'b0;
        r_head            <= r_head + 1'b1;
      end
      if (flush) begin
        r_valid <= r_valid & ~w_kill;
        r_exec  <= r_exec & ~w_kill;
        r_tail  <= r_cmt;
      end else begin
        if (w_alloc) begin
          r_valid[w_tail_i] <= 1'b1;
          r_exec[w_tail_i]  <= 1'b0;
          r_rob[w_tail_i]   <= alloc_rob_idx;
          r_tail            <= r_tail + 1'b1;
        end
        if (w_exec) begin
          r_exec[exec_sq_idx] <= 1'b1;
          r_addr[exec_sq_idx] <= exec_addr;
          r_data[exec_sq_idx] <= exec_data;
          r_be[exec_sq_idx]   <= exec_be;
        end
        if (w_commit) r_cmt <= r_cmt + 1'b1;
      end
    end
  end
`ifdef SQ_FORWARD_EN
  sq_fwd_match #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W), .BE_W(BE_W)
  ) u_fwd (
    .i_head(r_head), .i_ld_idx(ld_sq_idx), .i_ld_addr(ld_addr), .i_ld_be(ld_be),
    .i_valid(r_valid), .i_exec(r_exec), .i_addr(r_addr), .i_data(r_data), .i_be(r_be),
    .o_hit(w_hit), .o_stall(w_stall), .o_data(w_fwd)
  );
`else
  localparam int OFF = $clog2(BE_W);
  logic [IDX_W:0]   w_span;
  logic [IDX_W-1:0] w_e;
  logic             w_unused;
  assign w_unused = ^{ld_be, ld_addr};
  assign w_hit    = 1'b0;
  assign w_fwd    = '0;
  always_comb begin
    w_span  = ld_sq_idx - r_head;
    w_e     = '0;
    w_stall = 1'b0;
    for (int d = 0; d < DEPTH; d++) begin
      w_e = w_head_i + IDX_W'(d);
      if ((IDX_W+1)'(d) < w_span && r_valid[w_e] &&
          (!r_exec[w_e] || r_addr[w_e][ADDR_W-1:OFF] == ld_addr[ADDR_W-1:OFF]))
        w_stall = 1'b1;
    end
  end
`endif
  assign fwd_hit   = ld_valid && w_hit;
  assign fwd_stall = ld_valid && w_stall;
  assign fwd_data  = ld_valid ? w_fwd : '0;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of alloc/exec/commit/drain/flush/forwarding on store_buffer.
module tb_store_buffer;
  localparam int DEPTH = 8, IDX_W = 3, ADDR_W = 32, DATA_W = 32, ROB_W = 5;
  logic clk = 1'b0, reset;
  logic alloc_valid, alloc_ready, exec_valid, commit_valid, flush;
  logic [ROB_W-1:0] alloc_rob_idx;
  logic [IDX_W:0] alloc_sq_idx, ld_sq_idx, sq_count;
  logic [IDX_W-1:0] exec_sq_idx;
  logic [ADDR_W-1:0] exec_addr, mem_req_addr, ld_addr;
  logic [DATA_W-1:0] exec_data, mem_req_data, fwd_data;
  logic [3:0] exec_be, mem_req_be, ld_be;
  logic mem_req_valid, mem_req_ready, ld_valid, fwd_hit, fwd_stall, sq_full, sq_empty;
  int n_chk = 0, n_err = 0;
  logic [IDX_W:0] idx_q [4];
  always #5 clk = ~clk;
  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_rob_idx(alloc_rob_idx), .alloc_sq_idx(alloc_sq_idx), .exec_valid(exec_valid),
    .exec_sq_idx(exec_sq_idx), .exec_addr(exec_addr), .exec_data(exec_data), .exec_be(exec_be),
    .commit_valid(commit_valid), .flush(flush), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_be(mem_req_be), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_be(ld_be),
    .ld_sq_idx(ld_sq_idx), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .sq_full(sq_full), .sq_empty(sq_empty), .sq_count(sq_count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear;
    alloc_valid = 0; alloc_rob_idx = 0; exec_valid = 0; exec_sq_idx = 0; exec_addr = 0;
    exec_data = 0; exec_be = 0; commit_valid = 0; flush = 0; mem_req_ready = 0;
    ld_valid = 0; ld_addr = 0; ld_be = 0; ld_sq_idx = 0;
  endtask
  task automatic do_reset;
    clear();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask
  task automatic do_alloc(input int n);
    alloc_valid = 1;
    repeat (n) begin
      alloc_rob_idx = alloc_rob_idx + 1;
      tick();
    end
    alloc_valid = 0;
  endtask
  task automatic do_exec(input logic [IDX_W-1:0] i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    exec_valid = 1; exec_sq_idx = i; exec_addr = a; exec_data = d; exec_be = b;
    tick();
    exec_valid = 0;
  endtask
  task automatic do_commit(input int n);
    commit_valid = 1;
    repeat (n) tick();
    commit_valid = 0;
  endtask
  task automatic probe(input logic [31:0] a, input logic [3:0] b, input logic [IDX_W:0] i);
    ld_valid = 1; ld_addr = a; ld_be = b; ld_sq_idx = i;
    #1;
  endtask
  initial begin
    // 1: reset state, fill to full, tail sequence with wrap bit
    do_reset();
    check("rst_ready", alloc_ready, 1);
    check("rst_empty", sq_empty, 1);
    check("rst_full", sq_full, 0);
    check("rst_count", sq_count, 0);
    check("rst_memv", mem_req_valid, 0);
    check("rst_fwd", {fwd_hit, fwd_stall, fwd_data}, 0);
    for (int i = 0; i < DEPTH; i++) begin
      check("alloc_idx", alloc_sq_idx, i);
      do_alloc(1);
    end
    check("full", sq_full, 1);
    check("full_ready", alloc_ready, 0);
    check("full_count", sq_count, 8);
    check("full_idx", alloc_sq_idx, 8);
    // 4: full queue, drain+commit+alloc in one cycle
    do_exec(0, 32'h300, 32'h33333333, 4'hF);
    do_exec(1, 32'h304, 32'h44444444, 4'hF);
    do_commit(1);
    mem_req_ready = 1; commit_valid = 1; alloc_valid = 1;
    #1;
    check("t4_ready", alloc_ready, 0);
    check("t4_addr", mem_req_addr, 32'h300);
    tick();
    clear();
    check("t4_count", sq_count, 7);
    check("t4_idx", alloc_sq_idx, 8);
    check("t4_next", {mem_req_valid, mem_req_addr}, {1'b1, 32'h304});
    // 2: drain with backpressure
    do_reset();
    do_alloc(2);
    do_exec(0, 32'h100, 32'hDEADBEEF, 4'hF);
    check("t2_nocommit", mem_req_valid, 0);
    do_commit(1);
    for (int i = 0; i < 3; i++) begin
      check("t2_hold", {mem_req_valid, mem_req_addr, mem_req_data, mem_req_be}, {1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
      tick();
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    check("t2_count", sq_count, 1);
    check("t2_memv", mem_req_valid, 0);
    // 3: flush discards speculative entries, same-cycle alloc ignored
    do_reset();
    do_alloc(3);
    do_exec(0, 32'h140, 32'hA5A5A5A5, 4'h3);
    do_exec(1, 32'h144, 32'h5A5A5A5A, 4'hF);
    do_commit(1);
    flush = 1; alloc_valid = 1; commit_valid = 1;
    tick();
    clear();
    check("t3_count", sq_count, 1);
    check("t3_tail", alloc_sq_idx, 1);
    check("t3_mem", {mem_req_valid, mem_req_addr, mem_req_be}, {1'b1, 32'h140, 4'h3});
    do_exec(1, 32'h148, 32'h0, 4'hF);
    do_commit(1);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    check("t3_empty", sq_empty, 1);
    check("t3_memv", mem_req_valid, 0);
    // 5: load probes
    do_reset();
    do_alloc(2);
    do_exec(0, 32'h200, 32'h11111111, 4'hF);
    do_exec(1, 32'h200, 32'h22222222, 4'hF);
    probe(32'h200, 4'h3, 2);
`ifdef SQ_FORWARD_EN
    check("t5_hit", {fwd_hit, fwd_stall, fwd_data}, {2'b10, 32'h22222222});
`else
    check("t5_hit", {fwd_hit, fwd_stall, fwd_data}, {2'b01, 32'h0});
`endif
    probe(32'h200, 4'h3, 0);
    check("t5_none_older", {fwd_hit, fwd_stall}, 0);
    probe(32'h300, 4'h3, 2);
    check("t5_nomatch", {fwd_hit, fwd_stall}, 0);
    ld_valid = 0;
    #1;
    check("t5_ldoff", {fwd_hit, fwd_stall, fwd_data}, 0);
    do_reset();
    do_alloc(1);
    do_exec(0, 32'h200, 32'h11111111, 4'h1);
    probe(32'h202, 4'h3, 1);
    check("t5_partial", {fwd_hit, fwd_stall, fwd_data}, {2'b01, 32'h0});
    ld_valid = 0;
    do_alloc(1);
    probe(32'h400, 4'h1, 2);
    check("t5_unexec", {fwd_hit, fwd_stall}, 2'b01);
    ld_valid = 0;
    // 6: commit of unexecuted entry ignored, then wrap stress in order
    do_reset();
    do_alloc(1);
    do_commit(1);
    check("t6_ign", {mem_req_valid, sq_count}, {1'b0, 4'd1});
    do_reset();
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 4; j++) begin
        idx_q[j] = alloc_sq_idx;
        do_alloc(1);
      end
      for (int j = 0; j < 4; j++)
        do_exec(idx_q[j][IDX_W-1:0], 32'h1000 + 32'(4 * (b * 4 + j)), 32'hC0DE0000 + 32'(b * 4 + j), 4'hF);
      do_commit(4);
      mem_req_ready = 1;
      for (int j = 0; j < 4; j++) begin
        check("t6_drain", {mem_req_valid, mem_req_addr, mem_req_data},
              {1'b1, 32'h1000 + 32'(4 * (b * 4 + j)), 32'hC0DE0000 + 32'(b * 4 + j)});
        tick();
      end
      mem_req_ready = 0;
      check("t6_empty", sq_empty, 1);
    end
    check("t6_wrap_idx", alloc_sq_idx, 5'd24 % 16);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
